// File: rtl/input_route_unit.sv
// Input-port route computation stage: picks an output direction from each head flit
// (XY or YX), holds it for the rest of the packet, and drops packets that would turn back.
module input_route_unit #(
  parameter int          FLIT_W  = 64,
  parameter int          COORD_W = 16,
  parameter logic [2:0]  PORT_ID = 3'b011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] router_x,
  input  logic [COORD_W-1:0] router_y,
  input  logic               algo_sel,
  input  logic [FLIT_W-1:0]  in_flit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FLIT_W-1:0]  out_flit,
  output logic [2:0]         out_port,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_proto,
  output logic               drop_pulse
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  localparam logic [2:0] DIR_N   = 3'b000;
  localparam logic [2:0] DIR_S   = 3'b001;
  localparam logic [2:0] DIR_E   = 3'b010;
  localparam logic [2:0] DIR_W   = 3'b011;
  localparam logic [2:0] DIR_L   = 3'b100;
  localparam logic [2:0] INVALID = 3'b111;

  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  state_t             state;
  logic [2:0]         route_reg;
  logic [2:0]         head_route;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [1:0]         ftype;
  logic               accept;

  assign dest_x   = in_flit[FLIT_W-1 -: COORD_W];
  assign dest_y   = in_flit[FLIT_W-1-COORD_W -: COORD_W];
  assign ftype    = in_flit[1:0];
  assign in_ready = (state == DROP) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    head_route = INVALID;
    if ((dest_x == router_x) && (dest_y == router_y)) begin
      head_route = DIR_L;
    end else if (!algo_sel) begin
      if (dest_x != router_x) head_route = (dest_x > router_x) ? DIR_E : DIR_W;
      else                    head_route = (dest_y < router_y) ? DIR_N : DIR_S;
    end else begin
      if (dest_y != router_y) head_route = (dest_y > router_y) ? DIR_S : DIR_N;
      else                    head_route = (dest_x > router_x) ? DIR_E : DIR_W;
    end
    // A route back out of the port the packet arrived on is never legal.
    if (head_route == PORT_ID) head_route = INVALID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_port   <= INVALID;
      route_reg  <= INVALID;
      err_proto  <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      err_proto  <= 1'b0;
      drop_pulse <= 1'b0;
      // Clear on handshake; a flit loaded below in the same cycle overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        case (ftype)
          T_HEAD: begin
            if (state != IDLE) err_proto <= 1'b1;
            if (head_route != INVALID) begin
              out_flit  <= in_flit;
              out_port  <= head_route;
              out_valid <= 1'b1;
              route_reg <= head_route;
              state     <= ACTIVE;
            end else begin
              drop_pulse <= 1'b1;
              route_reg  <= INVALID;
              state      <= DROP;
            end
          end
          T_BODY, T_TAIL: begin
            if (state == IDLE) begin
              err_proto <= 1'b1;
            end else begin
              if (state == ACTIVE) begin
                out_flit  <= in_flit;
                out_port  <= route_reg;
                out_valid <= 1'b1;
              end
              if (ftype == T_TAIL) state <= IDLE;
            end
          end
          default: begin
            if (state != DROP) err_proto <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_route_unit.sv
// Scoreboard bench for input_route_unit: forwarded flits are queued when accepted
// and compared (flit, port, latency) when they leave through the output handshake.
module tb_input_route_unit;

  localparam logic [2:0] N = 3'b000, S = 3'b001, E = 3'b010, L = 3'b100;
  localparam logic [1:0] HEAD = 2'b11, BODY = 2'b01, TAIL = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] router_x, router_y;
  logic        algo_sel;
  logic [63:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_flit;
  logic [2:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        busy, err_proto, drop_pulse;

  typedef struct {
    logic [63:0] flit;
    logic [2:0]  port;
    int unsigned cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned last_waits;
  logic [29:0] seq = '0;
  logic [63:0] held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_route_unit #(.FLIT_W(64), .COORD_W(16), .PORT_ID(3'b011)) dut (
    .clk(clk), .reset(reset), .router_x(router_x), .router_y(router_y),
    .algo_sel(algo_sel), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_proto(err_proto), .drop_pulse(drop_pulse)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mk(input logic [15:0] x, input logic [15:0] y, input logic [1:0] t);
    seq = seq + 1;
    return {x, y, seq, t};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_flit, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_flit", out_flit, e.flit);
        check("out_port", {61'd0, out_port}, {61'd0, e.port});
        if (e.lat) check("latency", cyc - e.cyc, 1);
      end
    end
  end

  // Presents a flit, waits (bounded) for acceptance, returns #1 after the accepting edge.
  task automatic send(input logic [63:0] f, input bit fwd, input logic [2:0] port, input bit lat);
    int unsigned waits = 0;
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", waits, 0);
      in_valid = 1'b0;
      last_waits = waits;
      return;
    end
    if (fwd) sb.push_back('{f, port, cyc, lat});
    @(posedge clk);
    #1;
    last_waits = waits;
  endtask

  task automatic pulse_chk(input string tag, input bit e, input bit d);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, err_proto, e);
    check({tag, "_drop"}, drop_pulse, d);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_clr"}, err_proto, 0);
    check({tag, "_drop_clr"}, drop_pulse, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; router_x = 16'd2; router_y = 16'd2; algo_sel = 1'b0;
    in_flit = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_port", out_port, 3'b111);
    check("rst_out_flit", out_flit, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_proto, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // XY packet east, back-to-back
    algo_sel = 1'b0;
    send(mk(5, 1, HEAD), 1, E, 1);
    check("busy_active", busy, 1);
    send(mk(5, 1, BODY), 1, E, 1);
    check("thru_body1", last_waits, 0);
    send(mk(5, 1, BODY), 1, E, 1);
    check("thru_body2", last_waits, 0);
    send(mk(5, 1, TAIL), 1, E, 1);
    in_valid = 1'b0;
    check("busy_after_tail", busy, 0);
    @(posedge clk); #1;

    // YX packet north; algo_sel change mid-packet must not matter
    algo_sel = 1'b1;
    send(mk(5, 1, HEAD), 1, N, 1);
    algo_sel = 1'b0;
    send(mk(5, 1, BODY), 1, N, 1);
    send(mk(5, 1, BODY), 1, N, 1);
    send(mk(5, 1, TAIL), 1, N, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Local delivery, then a packet routed back west to its own port is dropped
    send(mk(2, 2, HEAD), 1, L, 1);
    send(mk(2, 2, TAIL), 1, L, 1);
    send(mk(0, 2, HEAD), 0, 3'b111, 0);
    pulse_chk("drop_head", 0, 1);
    check("drop_busy", busy, 1);
    out_ready = 1'b0;
    send(mk(0, 2, BODY), 0, 3'b111, 0);
    check("drop_ready_body", last_waits, 0);
    check("drop_in_ready", in_ready, 1);
    send(mk(0, 2, TAIL), 0, 3'b111, 0);
    check("drop_ready_tail", last_waits, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("drop_idle", busy, 0);
    @(posedge clk); #1;

    // Backpressure: three stalled cycles mid-packet
    send(mk(5, 1, HEAD), 1, E, 1);
    held = mk(5, 1, BODY);
    send(held, 1, E, 0);
    out_ready = 1'b0;
    in_flit = mk(5, 1, BODY);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_flit", out_flit, held);
      check("stall_port", out_port, E);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(in_flit, 1, E, 0);
    send(mk(5, 1, TAIL), 1, E, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Protocol errors: body in IDLE, new head while ACTIVE re-routes south
    send(mk(9, 9, BODY), 0, 3'b111, 0);
    pulse_chk("idle_body", 1, 0);
    send(mk(5, 1, HEAD), 1, E, 1);
    send(mk(5, 1, BODY), 1, E, 1);
    send(mk(2, 4, HEAD), 1, S, 1);
    pulse_chk("active_head", 1, 0);
    send(mk(2, 4, BODY), 1, S, 1);
    send(mk(2, 4, TAIL), 1, S, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a head flit is held on the output
    out_ready = 1'b0;
    send(mk(5, 1, HEAD), 0, E, 0);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_port", out_port, 3'b111);
    check("mid_rst_busy", busy, 0);
    send(mk(5, 1, BODY), 0, 3'b111, 0);
    pulse_chk("post_rst_body", 1, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
